// File: rtl/mul_sequencer.sv
// ---------------------------------------------------------------------------
// mul_sequencer
//   Shift-and-add multiply controller. It uses an external 16-bit function
//   unit as its datapath and issues one function-select micro-op per cycle:
//   pass A, A+B, B<<1 or B>>1. It forms the unsigned product X*Y modulo
//   2^WIDTH and raises a sticky overflow flag when the true product does not
//   fit in WIDTH bits.
//
//   Configuration macro: MULSEQ_EARLY_EXIT_EN
//     defined   : stops as soon as the shifted multiplier becomes zero, as
//                 reported by Z_I in TEST and SHR.
//     undefined : ignores Z_I and always performs exactly WIDTH SHR steps,
//                 counted by a 5-bit iteration counter.
//
// Ports
//   CLK, RESET        clock, synchronous active-high reset
//   START             one-cycle request, accepted only while idle
//   X_IN, Y_IN        multiplicand and multiplier, captured on accepted START
//   BUSY              high in every state except IDLE
//   DONE              one-cycle pulse; PRODUCT and OVF are valid
//   PRODUCT, OVF      result, held until the next completed operation
//   FS_O, A_O, B_O    registered function select and operands to the unit
//   D_I, C_I, Z_I     function unit result, carry and zero flags
// ---------------------------------------------------------------------------
module mul_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] X_IN,
  input  logic [WIDTH-1:0] Y_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] PRODUCT,
  output logic             OVF,
  output logic [3:0]       FS_O,
  output logic [WIDTH-1:0] A_O,
  output logic [WIDTH-1:0] B_O,
  input  logic [WIDTH-1:0] D_I,
  input  logic             C_I,
  input  logic             Z_I
);

  localparam logic [3:0] FS_PASS = 4'b0000;
  localparam logic [3:0] FS_ADD  = 4'b0010;
  localparam logic [3:0] FS_SHL  = 4'b1110;
  localparam logic [3:0] FS_SHR  = 4'b1101;
  localparam logic [3:0] FS_HOLD = 4'b1111;

  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-2:0] ZERO_W1 = {(WIDTH-1){1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TEST = 3'd1,
    ST_ADD  = 3'd2,
    ST_SHL  = 3'd3,
    ST_SHR  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] x_r, x_nxt_s;
  logic [WIDTH-1:0] y_r, y_nxt_s;
  logic [WIDTH-1:0] p_r, p_nxt_s;
  logic             ovf_r, ovf_nxt_s;
  logic [WIDTH-1:0] product_r, product_nxt_s;
  logic             ovf_out_r, ovf_out_nxt_s;
  logic             busy_r, done_r;
  logic [3:0]       fs_r, fs_nxt_s;
  logic [WIDTH-1:0] a_r, a_nxt_s;
  logic [WIDTH-1:0] b_r, b_nxt_s;

`ifndef MULSEQ_EARLY_EXIT_EN
  logic [4:0] cnt_r, cnt_nxt_s;
  // Termination comes from the counter, so the zero flag is not consumed.
  logic z_unused_s;
  assign z_unused_s = Z_I;
`endif

  // Next-state, working-register and next-output computation.
  always_comb begin
    state_nxt_s = state_r;
    x_nxt_s     = x_r;
    y_nxt_s     = y_r;
    p_nxt_s     = p_r;
    ovf_nxt_s   = ovf_r;
`ifndef MULSEQ_EARLY_EXIT_EN
    cnt_nxt_s   = cnt_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (START) begin
          x_nxt_s     = X_IN;
          y_nxt_s     = Y_IN;
          p_nxt_s     = ZERO_W;
          ovf_nxt_s   = 1'b0;
`ifndef MULSEQ_EARLY_EXIT_EN
          cnt_nxt_s   = 5'd0;
`endif
          state_nxt_s = ST_TEST;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_TEST: begin
`ifdef MULSEQ_EARLY_EXIT_EN
        if (Z_I) begin
          state_nxt_s = ST_DONE;
        end else if (y_r[0]) begin
          state_nxt_s = ST_ADD;
        end else begin
          state_nxt_s = ST_SHL;
        end
`else
        if (y_r[0]) begin
          state_nxt_s = ST_ADD;
        end else begin
          state_nxt_s = ST_SHL;
        end
`endif
      end
      ST_ADD: begin
        p_nxt_s     = D_I;
        ovf_nxt_s   = ovf_r | C_I;
        state_nxt_s = ST_SHL;
      end
      ST_SHL: begin
        x_nxt_s = D_I;
        // A bit shifted out of X matters only if a multiplier bit above the
        // current one will still add this X into P.
        if (x_r[WIDTH-1] && (y_r[WIDTH-1:1] != ZERO_W1)) begin
          ovf_nxt_s = 1'b1;
        end else begin
          ovf_nxt_s = ovf_r;
        end
        state_nxt_s = ST_SHR;
      end
      ST_SHR: begin
        y_nxt_s = D_I;
`ifdef MULSEQ_EARLY_EXIT_EN
        if (Z_I) begin
          state_nxt_s = ST_DONE;
        end else if (D_I[0]) begin
          state_nxt_s = ST_ADD;
        end else begin
          state_nxt_s = ST_SHL;
        end
`else
        cnt_nxt_s = cnt_r + 5'd1;
        if (cnt_r == 5'(WIDTH - 1)) begin
          state_nxt_s = ST_DONE;
        end else if (D_I[0]) begin
          state_nxt_s = ST_ADD;
        end else begin
          state_nxt_s = ST_SHL;
        end
`endif
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being
    // entered and the register values that state will see.
    fs_nxt_s = FS_HOLD;
    a_nxt_s  = ZERO_W;
    b_nxt_s  = ZERO_W;
    case (state_nxt_s)
      ST_TEST: begin
        fs_nxt_s = FS_PASS;
        a_nxt_s  = y_nxt_s;
      end
      ST_ADD: begin
        fs_nxt_s = FS_ADD;
        a_nxt_s  = p_nxt_s;
        b_nxt_s  = x_nxt_s;
      end
      ST_SHL: begin
        fs_nxt_s = FS_SHL;
        b_nxt_s  = x_nxt_s;
      end
      ST_SHR: begin
        fs_nxt_s = FS_SHR;
        b_nxt_s  = y_nxt_s;
      end
      default: begin
        fs_nxt_s = FS_HOLD;
      end
    endcase

    if (state_nxt_s == ST_DONE) begin
      product_nxt_s = p_nxt_s;
      ovf_out_nxt_s = ovf_nxt_s;
    end else begin
      product_nxt_s = product_r;
      ovf_out_nxt_s = ovf_out_r;
    end
  end

  // State, working registers and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r   <= ST_IDLE;
      x_r       <= ZERO_W;
      y_r       <= ZERO_W;
      p_r       <= ZERO_W;
      ovf_r     <= 1'b0;
      product_r <= ZERO_W;
      ovf_out_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      fs_r      <= FS_HOLD;
      a_r       <= ZERO_W;
      b_r       <= ZERO_W;
`ifndef MULSEQ_EARLY_EXIT_EN
      cnt_r     <= 5'd0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      x_r       <= x_nxt_s;
      y_r       <= y_nxt_s;
      p_r       <= p_nxt_s;
      ovf_r     <= ovf_nxt_s;
      product_r <= product_nxt_s;
      ovf_out_r <= ovf_out_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
      done_r    <= (state_nxt_s == ST_DONE);
      fs_r      <= fs_nxt_s;
      a_r       <= a_nxt_s;
      b_r       <= b_nxt_s;
`ifndef MULSEQ_EARLY_EXIT_EN
      cnt_r     <= cnt_nxt_s;
`endif
    end
  end

  assign BUSY    = busy_r;
  assign DONE    = done_r;
  assign PRODUCT = product_r;
  assign OVF     = ovf_out_r;
  assign FS_O    = fs_r;
  assign A_O     = a_r;
  assign B_O     = b_r;

endmodule
